// File: rtl/mac_seq_pkg.sv
// Shared types for the weight sequencer: engine state encodings and the
// load->exec handoff record.
package mac_seq_pkg;

  // Handoff field widths; the sequencer's CNT_WIDTH / BUFFER_ADDR_WIDTH must not exceed these.
  localparam int HO_ADDR_W = 15;
  localparam int HO_CNT_W  = 16;

  typedef enum logic [1:0] {L_IDLE, L_READ, L_SHIFT_TAIL, L_HOLD} load_state_e;
  typedef enum logic [1:0] {E_IDLE, E_SET, E_RUN, E_DRAIN}        exec_state_e;

  typedef struct packed {
    logic [HO_ADDR_W-1:0] act_base;
    logic [HO_CNT_W-1:0]  num_vectors;
  } handoff_t;

endpackage

// File: rtl/mac_weight_load_engine.sv
// Weight preload engine: reads ARRAY_ROWS weight words, shifts them into the
// tile shadow registers and parks the command fields until exec commits them.
module mac_weight_load_engine
  import mac_seq_pkg::*;
#(
  parameter int ARRAY_ROWS        = 16,
  parameter int CNT_WIDTH         = 16,
  parameter int BUFFER_ADDR_WIDTH = 15
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_accept,
  input  logic [BUFFER_ADDR_WIDTH-1:0] cmd_weight_base,
  input  logic [BUFFER_ADDR_WIDTH-1:0] cmd_act_base,
  input  logic [CNT_WIDTH-1:0]         cmd_num_vectors,
  input  logic                         commit,
  output load_state_e                  state,
  output logic                         wbuf_rd_en,
  output logic [BUFFER_ADDR_WIDTH-1:0] wbuf_rd_addr,
  output logic                         prepare_weight,
  output handoff_t                     handoff
);

  localparam int RW = $clog2(ARRAY_ROWS + 1);

  load_state_e                  state_q, state_d;
  logic [RW-1:0]                rd_cnt_q, rd_cnt_d;
  logic [BUFFER_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                         prep_q, prep_d;
  handoff_t                     ho_q, ho_d;
  logic                         last_rd;

  assign last_rd = (rd_cnt_q == RW'(ARRAY_ROWS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= L_IDLE;
      rd_cnt_q  <= '0;
      rd_addr_q <= '0;
      prep_q    <= 1'b0;
      ho_q      <= '0;
    end else begin
      state_q   <= state_d;
      rd_cnt_q  <= rd_cnt_d;
      rd_addr_q <= rd_addr_d;
      prep_q    <= prep_d;
      ho_q      <= ho_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      L_IDLE:       if (cmd_accept) state_d = L_READ;
      L_READ:       if (last_rd)    state_d = L_SHIFT_TAIL;
      L_SHIFT_TAIL:                 state_d = L_HOLD;
      L_HOLD:       if (commit)     state_d = L_IDLE;
      default:                      state_d = L_IDLE;
    endcase
  end

  // Read data lands one cycle after the strobe, so the shift strobe is the strobe delayed.
  always_comb begin
    rd_cnt_d   = rd_cnt_q;
    rd_addr_d  = rd_addr_q;
    ho_d       = ho_q;
    wbuf_rd_en = (state_q == L_READ);
    prep_d     = wbuf_rd_en;
    if (state_q == L_IDLE && cmd_accept) begin
      rd_cnt_d         = '0;
      rd_addr_d        = cmd_weight_base;
      ho_d.act_base    = HO_ADDR_W'(cmd_act_base);
      ho_d.num_vectors = HO_CNT_W'(cmd_num_vectors);
    end else if (wbuf_rd_en) begin
      rd_cnt_d  = rd_cnt_q + 1'b1;
      rd_addr_d = rd_addr_q + 1'b1;
    end
  end

  assign state          = state_q;
  assign wbuf_rd_addr   = rd_addr_q;
  assign prepare_weight = prep_q;
  assign handoff        = ho_q;

endmodule

// File: rtl/mac_quad_weight_sequencer.sv
// Column sequencer: overlaps weight preload of the next command with
// activation streaming and accumulator drain of the current one.
module mac_quad_weight_sequencer
  import mac_seq_pkg::*;
#(
  parameter int ARRAY_ROWS        = 16,
  parameter int CNT_WIDTH         = 16,
  parameter int BUFFER_ADDR_WIDTH = 15,
  parameter int DRAIN_CYCLES      = 20
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [BUFFER_ADDR_WIDTH-1:0] cmd_weight_base,
  input  logic [BUFFER_ADDR_WIDTH-1:0] cmd_act_base,
  input  logic [CNT_WIDTH-1:0]         cmd_num_vectors,
  output logic                         wbuf_rd_en,
  output logic [BUFFER_ADDR_WIDTH-1:0] wbuf_rd_addr,
  output logic                         prepare_weight,
  output logic                         set_weight,
  output logic                         act_rd_en,
  output logic [BUFFER_ADDR_WIDTH-1:0] act_rd_addr,
  output logic                         busy,
  output logic                         done
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  load_state_e                  l_state;
  handoff_t                     handoff;
  logic                         commit;
  exec_state_e                  e_state_q, e_state_d, e_cur;
  logic [CNT_WIDTH-1:0]         vec_cnt_q, vec_cnt_d;
  logic [BUFFER_ADDR_WIDTH-1:0] act_addr_q, act_addr_d;
  logic [DW-1:0]                drain_cnt_q, drain_cnt_d;
  logic                         drain_last;

  assign cmd_ready = (l_state == L_IDLE) & ~rst;

  mac_weight_load_engine #(
    .ARRAY_ROWS       (ARRAY_ROWS),
    .CNT_WIDTH        (CNT_WIDTH),
    .BUFFER_ADDR_WIDTH(BUFFER_ADDR_WIDTH)
  ) u_load (
    .clk            (clk),
    .rst            (rst),
    .cmd_accept     (cmd_valid & cmd_ready),
    .cmd_weight_base(cmd_weight_base),
    .cmd_act_base   (cmd_act_base),
    .cmd_num_vectors(cmd_num_vectors),
    .commit         (commit),
    .state          (l_state),
    .wbuf_rd_en     (wbuf_rd_en),
    .wbuf_rd_addr   (wbuf_rd_addr),
    .prepare_weight (prepare_weight),
    .handoff        (handoff)
  );

  // E_SET is the idle cycle in which preloaded weights are committed; it is
  // decoded rather than registered so the commit lands the cycle load reaches hold.
  assign commit     = (e_state_q == E_IDLE) && (l_state == L_HOLD);
  assign e_cur      = commit ? E_SET : e_state_q;
  assign drain_last = (drain_cnt_q == DW'(DRAIN_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      e_state_q   <= E_IDLE;
      vec_cnt_q   <= '0;
      act_addr_q  <= '0;
      drain_cnt_q <= '0;
    end else begin
      e_state_q   <= e_state_d;
      vec_cnt_q   <= vec_cnt_d;
      act_addr_q  <= act_addr_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  always_comb begin
    e_state_d = e_state_q;
    unique case (e_cur)
      E_IDLE:  e_state_d = E_IDLE;
      E_SET:   e_state_d = (handoff.num_vectors == '0) ? E_DRAIN : E_RUN;
      E_RUN:   if (vec_cnt_q == CNT_WIDTH'(1)) e_state_d = E_DRAIN;
      E_DRAIN: if (drain_last) e_state_d = E_IDLE;
      default: e_state_d = E_IDLE;
    endcase
  end

  always_comb begin
    vec_cnt_d   = vec_cnt_q;
    act_addr_d  = act_addr_q;
    drain_cnt_d = drain_cnt_q;
    unique case (e_cur)
      E_SET: begin
        vec_cnt_d   = CNT_WIDTH'(handoff.num_vectors);
        act_addr_d  = BUFFER_ADDR_WIDTH'(handoff.act_base);
        drain_cnt_d = '0;
      end
      E_RUN: begin
        vec_cnt_d  = vec_cnt_q - 1'b1;
        act_addr_d = act_addr_q + 1'b1;
      end
      E_DRAIN: drain_cnt_d = drain_cnt_q + 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    set_weight  = (e_cur == E_SET);
    act_rd_en   = (e_state_q == E_RUN);
    act_rd_addr = act_addr_q;
    done        = (e_state_q == E_DRAIN) && drain_last;
    busy        = (l_state != L_IDLE) || (e_state_q != E_IDLE);
  end

endmodule

// File: tb/tb_mac_quad_weight_sequencer.sv
// Scoreboard bench: each accepted command is expanded into timed expected
// events from the timing rules; a negedge monitor compares every cycle.
module tb_mac_quad_weight_sequencer;
  localparam int AR = 4, CW = 16, AW = 15, DC = 5;

  logic          clk = 1'b0, rst;
  logic          cmd_valid, cmd_ready;
  logic [AW-1:0] cmd_weight_base, cmd_act_base;
  logic [CW-1:0] cmd_num_vectors;
  logic          wbuf_rd_en, prepare_weight, set_weight, act_rd_en, busy, done;
  logic [AW-1:0] wbuf_rd_addr, act_rd_addr;

  always #5 clk = ~clk;

  mac_quad_weight_sequencer #(
    .ARRAY_ROWS(AR), .CNT_WIDTH(CW), .BUFFER_ADDR_WIDTH(AW), .DRAIN_CYCLES(DC)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_weight_base(cmd_weight_base), .cmd_act_base(cmd_act_base),
    .cmd_num_vectors(cmd_num_vectors), .wbuf_rd_en(wbuf_rd_en),
    .wbuf_rd_addr(wbuf_rd_addr), .prepare_weight(prepare_weight),
    .set_weight(set_weight), .act_rd_en(act_rd_en), .act_rd_addr(act_rd_addr),
    .busy(busy), .done(done)
  );

  typedef struct {int cyc; logic [AW-1:0] addr;} ev_t;
  ev_t wq[$], aq[$];
  int  pq[$], sq[$], dq[$], bsy_lo[$], bsy_hi[$];
  int  cyc = 0, load_free = 0, exec_free = 0, acc_cyc = -1, zero_chk = -1;
  bit  init_rst = 1'b1;
  int  checks = 0, errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    bit e;
    if (cyc >= 1) begin
      chk("cmd_ready", cmd_ready, !rst && (cyc >= load_free || cyc == acc_cyc));
      while (bsy_hi.size() > 0 && bsy_hi[0] < cyc) begin
        void'(bsy_lo.pop_front());
        void'(bsy_hi.pop_front());
      end
      e = 1'b0;
      foreach (bsy_lo[i]) if (bsy_lo[i] <= cyc && cyc <= bsy_hi[i]) e = 1'b1;
      chk("busy", busy, e);
      e = wq.size() > 0 && wq[0].cyc == cyc;
      chk("wbuf_rd_en", wbuf_rd_en, e);
      if (e) begin chk("wbuf_rd_addr", wbuf_rd_addr, wq[0].addr); void'(wq.pop_front()); end
      e = pq.size() > 0 && pq[0] == cyc;
      chk("prepare_weight", prepare_weight, e);
      if (e) void'(pq.pop_front());
      e = sq.size() > 0 && sq[0] == cyc;
      chk("set_weight", set_weight, e);
      if (e) void'(sq.pop_front());
      e = aq.size() > 0 && aq[0].cyc == cyc;
      chk("act_rd_en", act_rd_en, e);
      if (e) begin chk("act_rd_addr", act_rd_addr, aq[0].addr); void'(aq.pop_front()); end
      e = dq.size() > 0 && dq[0] == cyc;
      chk("done", done, e);
      if (e) void'(dq.pop_front());
      if (init_rst || cyc == zero_chk) begin
        chk("wbuf_rd_addr_reset", wbuf_rd_addr, 0);
        chk("act_rd_addr_reset", act_rd_addr, 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expand one accepted command into its expected output timeline.
  task automatic model_accept(input logic [AW-1:0] wb, input logic [AW-1:0] ab,
                              input logic [CW-1:0] n);
    int t, s, d;
    t = cyc;
    s = (t + AR + 2 > exec_free) ? t + AR + 2 : exec_free;
    d = s + int'(n) + DC;
    for (int i = 0; i < AR; i++) begin
      ev_t ev;
      ev.cyc = t + 1 + i; ev.addr = wb + AW'(i);
      wq.push_back(ev);
      pq.push_back(t + 2 + i);
    end
    sq.push_back(s);
    for (int k = 0; k < int'(n); k++) begin
      ev_t ev;
      ev.cyc = s + 1 + k; ev.addr = ab + AW'(k);
      aq.push_back(ev);
    end
    dq.push_back(d);
    bsy_lo.push_back(t + 1);
    bsy_hi.push_back(d);
    acc_cyc   = t;
    load_free = s + 1;
    exec_free = d + 1;
  endtask

  // Offer a command until accepted; with scramble, cmd_valid is held with junk
  // fields during non-ready cycles, which the DUT must ignore.
  task automatic send(input logic [AW-1:0] wb, input logic [AW-1:0] ab,
                      input logic [CW-1:0] n, input bit scramble);
    int waited = 0;
    while (rst || cyc < load_free) begin
      cmd_valid       = scramble;
      cmd_weight_base = AW'($urandom);
      cmd_act_base    = AW'($urandom);
      cmd_num_vectors = CW'($urandom_range(0, 20));
      step();
      waited++;
      if (waited > 400) begin
        chk("accept_timeout", 1, 0);
        cmd_valid = 1'b0;
        return;
      end
    end
    cmd_valid = 1'b1; cmd_weight_base = wb; cmd_act_base = ab; cmd_num_vectors = n;
    model_accept(wb, ab, n);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((cyc < exec_free || wq.size() + pq.size() + sq.size() + aq.size() + dq.size() > 0)
           && n < 1000) begin
      step();
      n++;
    end
    if (n >= 1000) chk("idle_timeout", 1, 0);
    step();
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0;
    cmd_weight_base = '0; cmd_act_base = '0; cmd_num_vectors = '0;
    step(); step(); step();
    rst = 1'b0; init_rst = 1'b0;

    send(15'h010, 15'h100, 16'd3, 1'b0);  wait_idle();
    send(15'h020, 15'h200, 16'd0, 1'b0);  wait_idle();
    send(15'h7FFE, 15'h7FFD, 16'd4, 1'b0); wait_idle();

    send(15'h100, 15'h300, 16'd10, 1'b0);
    send(15'h140, 15'h400, 16'd10, 1'b0);
    send(15'h180, 15'h500, 16'd2, 1'b1);
    wait_idle();

    // reset during the third preload cycle abandons the command entirely
    send(15'h010, 15'h100, 16'd3, 1'b0);
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    wq.delete(); pq.delete(); sq.delete(); aq.delete(); dq.delete();
    bsy_lo.delete(); bsy_hi.delete();
    load_free = cyc; exec_free = cyc; acc_cyc = -1; zero_chk = cyc;
    step();
    send(15'h010, 15'h100, 16'd3, 1'b0);  wait_idle();

    for (int i = 0; i < 30; i++) begin
      int gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) step();
      send(AW'($urandom), AW'($urandom), CW'($urandom_range(0, 12)), 1'($urandom_range(0, 1)));
    end
    wait_idle();
    chk("queues_empty", wq.size() + pq.size() + sq.size() + aq.size() + dq.size(), 0);
    step(); step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mac_quad_weight_sequencer.md
# mac_quad_weight_sequencer

Controller that sequences a column of `mac_quad_nomantissaout` tiles through weight preload, weight commit and activation streaming. It reads weight bytes from the weight buffer, drives `prepare_weight` to shift them into the tiles' shadow registers, and pulses `set_weight` to commit them. It then enables the activation stream for a commanded number of vectors and waits for the accumulator chain to drain. Weight preload for the next command overlaps execution of the current one.

## Interface
- `ARRAY_ROWS`, 16: weight shift-chain depth; number of weight words per command.
- `CNT_WIDTH`, 16: width of the vector counter.
- `BUFFER_ADDR_WIDTH`, 15: weight/activation buffer address width.
- `DRAIN_CYCLES`, 20: cycles from the last activation until results are complete at the column output.
- `clk  in  1`: single clock, rising edge.
- `rst  in  1`: reset; synchronous, active-high.
- `cmd_valid  in  1`: command offered.
- `cmd_ready  out  1`: command accepted when `cmd_valid & cmd_ready`.
- `cmd_weight_base  in  BUFFER_ADDR_WIDTH`: first weight address.
- `cmd_act_base  in  BUFFER_ADDR_WIDTH`: first activation address.
- `cmd_num_vectors  in  CNT_WIDTH`: activation vectors to stream; 0 is legal.
- `wbuf_rd_en  out  1`: weight buffer read strobe; data returns the next cycle.
- `wbuf_rd_addr  out  BUFFER_ADDR_WIDTH`: weight read address.
- `prepare_weight  out  1`: shift strobe to the tiles; high while returned weight data is valid.
- `set_weight  out  1`: one-cycle commit of shadow weights.
- `act_rd_en  out  1`: activation read/stream enable.
- `act_rd_addr  out  BUFFER_ADDR_WIDTH`: activation address.
- `busy  out  1`: any engine not idle.
- `done  out  1`: one-cycle pulse when a command's drain completes.

## Operation
- Two engines.
  - Load engine states: L_IDLE, L_READ, L_SHIFT_TAIL, L_HOLD.
  - Exec engine states: E_IDLE, E_SET, E_RUN, E_DRAIN.
- Command acceptance:
  - `cmd_ready` = (load engine in L_IDLE) & ~`rst`.
  - On accept, the load engine latches all command fields and enters L_READ.
- Weight reads (L_READ):
  - Issues ARRAY_ROWS reads at `cmd_weight_base + i`, i = 0..ARRAY_ROWS-1.
  - Addition is modulo 2^BUFFER_ADDR_WIDTH (wrap, no error).
- Shift tail and hold:
  - L_SHIFT_TAIL lasts one cycle and covers the last read's return.
  - The engine then enters L_HOLD, holding the latched `act_base` and `num_vectors`.
- Commit handshake:
  - E_IDLE with load in L_HOLD → E_SET. `set_weight` = 1 for that one cycle.
  - In the same cycle the load engine returns to L_IDLE and hands the latched fields to the exec engine.
- E_SET transitions:
  - `num_vectors` = 0 → E_DRAIN.
  - Otherwise → E_RUN.
- E_RUN:
  - `act_rd_en` = 1 for exactly `num_vectors` cycles.
  - `act_rd_addr` = `act_base + k` (modulo wrap).
- E_DRAIN:
  - Lasts DRAIN_CYCLES cycles.
  - On the final cycle `done` = 1, then → E_IDLE.
- Overlap:
  - The load engine may accept and fully preload a new command while exec is in E_RUN/E_DRAIN.
  - It waits in L_HOLD; `set_weight` is never asserted outside E_IDLE→E_SET.
- Simultaneous events: `done` and the next E_SET are in different cycles. After `done`, E_IDLE lasts at least one cycle.
- `cmd_valid` while not ready: ignored, no state change.

## Timing
- Accept at cycle T:
  - `wbuf_rd_en` at T+1..T+ARRAY_ROWS.
  - `prepare_weight` at T+2..T+ARRAY_ROWS+1.
- If exec is idle:
  - `set_weight` at T+ARRAY_ROWS+2.
  - `act_rd_en` at T+ARRAY_ROWS+3..T+ARRAY_ROWS+2+N.
  - `done` at T+ARRAY_ROWS+2+N+DRAIN_CYCLES.
  - `cmd_ready` high again at T+ARRAY_ROWS+3.
- Reset values:
  - All outputs 0 during `rst`, including `cmd_ready`.
  - Addresses are 0; both engines are idle.
- Reset mid-operation:
  - The next cycle is fully idle; no `set_weight` or `done` is emitted.
  - Partially shifted weights are abandoned.
- All outputs are registered or decoded from state registers only. There is no combinational path from inputs to outputs except `cmd_ready` (gated by `rst`).

## Structure
- Package `mac_seq_pkg`: load/exec state enums, and the drain/handoff field struct (act_base, num_vectors).
- Sub-module `mac_weight_load_engine`: L_* FSM, read address counter, one-cycle-delayed `prepare_weight`.
- The top module holds the exec FSM, vector counter, drain counter and activation address.

## Test plan
- ARRAY_ROWS=4, DRAIN_CYCLES=5, one command at T=0 (base 0x010, N=3) → reads 0x010..0x013 at 1..4, `prepare_weight` 2..5, `set_weight` 6, `act_rd_en` 7..9, `done` 14.
- Two back-to-back commands (N=10 each) → second preload completes during E_RUN. Second `set_weight` occurs exactly 1 cycle after the first `done`; never two `set_weight` pulses in between.
- N=0 → `set_weight` at 6, no `act_rd_en`, `done` at 11.
- `cmd_weight_base`=0x7FFE, ARRAY_ROWS=4 → addresses 0x7FFE, 0x7FFF, 0x0000, 0x0001.
- `rst` asserted at cycle 3 of preload → next cycle: all outputs 0, `busy`=0; a fresh command behaves exactly as in scenario 1.
- `cmd_valid` held high while in L_HOLD → no second accept until the cycle after `set_weight`; fields captured from that cycle.
